// File: rtl/btb_update_ctrl_if.sv
// Request and BTB write-port bundle for btb_update_ctrl.
// slave = the controller, master = pipeline/BTB side that drives requests and observes writes.
interface btb_update_ctrl_if #(
  parameter int LOWER = 5
);
  logic             en;
  logic             br_valid;
  logic [63:0]      br_pc;
  logic [63:0]      br_target;
  logic             jmp_valid;
  logic [63:0]      jmp_pc;
  logic [63:0]      jmp_target;
  logic             flush_req;
  logic             btb_wr_en;
  logic [LOWER-3:0] btb_wr_index;
  logic [63:0]      btb_wr_tag;
  logic [63:0]      btb_wr_target;
  logic             btb_wr_valid;
  logic             flush_busy;
  logic             queue_full;
  logic             drop;

  modport master (
    output en, br_valid, br_pc, br_target, jmp_valid, jmp_pc, jmp_target, flush_req,
    input  btb_wr_en, btb_wr_index, btb_wr_tag, btb_wr_target, btb_wr_valid,
           flush_busy, queue_full, drop
  );

  modport slave (
    input  en, br_valid, br_pc, br_target, jmp_valid, jmp_pc, jmp_target, flush_req,
    output btb_wr_en, btb_wr_index, btb_wr_tag, btb_wr_target, btb_wr_valid,
           flush_busy, queue_full, drop
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: queues branch/jump updates, one BTB write per cycle, flush sweep.
// Optional BTB_UPD_STATS_EN adds saturating stat_writes/stat_drops counters.
module btb_update_ctrl #(
  parameter int LOWER   = 5,
  parameter int Q_DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  btb_update_ctrl_if.slave  bus
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_drops
`endif
);

  localparam int IW   = LOWER - 2;
  localparam int ROWS = 1 << IW;
  localparam int PW   = $clog2(Q_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [PW-1:0]   wr_ptr_r, wr_ptr_next_s;
  logic [PW-1:0]   rd_ptr_r, rd_ptr_next_s;
  logic [CW-1:0]   count_r, count_next_s;
  logic [IW-1:0]   sweep_r, sweep_next_s;
  logic [63:0]     mem_pc_r  [Q_DEPTH];
  logic [63:0]     mem_tgt_r [Q_DEPTH];

  logic            wr_en_r, wr_en_next_s;
  logic [IW-1:0]   wr_index_r, wr_index_next_s;
  logic [63:0]     wr_tag_r, wr_tag_next_s;
  logic [63:0]     wr_target_r, wr_target_next_s;
  logic            wr_valid_r, wr_valid_next_s;
  logic            flush_busy_r, flush_busy_next_s;
  logic            queue_full_r, queue_full_next_s;
  logic            drop_r, drop_next_s;

  logic            accept_ok_s, fifo_pop_s, pop_s;
  logic            br_acc_s, jmp_acc_s;
  logic [CW-1:0]   free_s;
  logic [1:0]      drop_cnt_s;
  logic [63:0]     head_pc_s, head_tgt_s;

  // Request acceptance: slots freed by this cycle's pop count; an empty FIFO forwards the first push.
  always_comb begin
    accept_ok_s = bus.en && !bus.flush_req && (state_r != ST_FLUSH);
    fifo_pop_s  = accept_ok_s && (count_r != {CW{1'b0}});
    free_s      = CW'(Q_DEPTH) - count_r + CW'(fifo_pop_s);
    br_acc_s    = bus.br_valid && accept_ok_s && (free_s != {CW{1'b0}});
    jmp_acc_s   = bus.jmp_valid && accept_ok_s &&
                  (free_s >= (br_acc_s ? CW'(2'd2) : CW'(2'd1)));
    pop_s       = fifo_pop_s || br_acc_s || jmp_acc_s;
    drop_cnt_s  = 2'(bus.br_valid && !br_acc_s) + 2'(bus.jmp_valid && !jmp_acc_s);
    if (count_r != {CW{1'b0}}) begin
      head_pc_s  = mem_pc_r[rd_ptr_r];
      head_tgt_s = mem_tgt_r[rd_ptr_r];
    end else if (br_acc_s) begin
      head_pc_s  = bus.br_pc;
      head_tgt_s = bus.br_target;
    end else begin
      head_pc_s  = bus.jmp_pc;
      head_tgt_s = bus.jmp_target;
    end
  end

  // FSM next state, FIFO pointers and next values of the registered write port.
  always_comb begin
    state_next_s      = state_r;
    sweep_next_s      = {IW{1'b0}};
    wr_ptr_next_s     = wr_ptr_r + PW'(br_acc_s) + PW'(jmp_acc_s);
    rd_ptr_next_s     = rd_ptr_r + PW'(pop_s);
    count_next_s      = count_r + CW'(br_acc_s) + CW'(jmp_acc_s) - CW'(pop_s);
    wr_en_next_s      = 1'b0;
    wr_index_next_s   = wr_index_r;
    wr_tag_next_s     = wr_tag_r;
    wr_target_next_s  = wr_target_r;
    wr_valid_next_s   = wr_valid_r;
    flush_busy_next_s = 1'b0;
    if (bus.flush_req) begin
      state_next_s      = ST_FLUSH;
      sweep_next_s      = IW'(1'b1);
      wr_ptr_next_s     = {PW{1'b0}};
      rd_ptr_next_s     = {PW{1'b0}};
      count_next_s      = {CW{1'b0}};
      wr_en_next_s      = 1'b1;
      wr_index_next_s   = {IW{1'b0}};
      wr_tag_next_s     = 64'd0;
      wr_target_next_s  = 64'd0;
      wr_valid_next_s   = 1'b0;
      flush_busy_next_s = 1'b1;
    end else begin
      case (state_r)
        ST_FLUSH: begin
          sweep_next_s      = sweep_r + IW'(1'b1);
          wr_en_next_s      = 1'b1;
          wr_index_next_s   = sweep_r;
          wr_tag_next_s     = 64'd0;
          wr_target_next_s  = 64'd0;
          wr_valid_next_s   = 1'b0;
          flush_busy_next_s = 1'b1;
          if (sweep_r == IW'(ROWS - 1)) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_FLUSH;
          end
        end
        ST_IDLE, ST_DRAIN: begin
          if (pop_s) begin
            wr_en_next_s     = 1'b1;
            wr_index_next_s  = head_pc_s[LOWER-1:2];
            wr_tag_next_s    = head_pc_s;
            wr_target_next_s = head_tgt_s;
            wr_valid_next_s  = 1'b1;
          end else begin
            wr_en_next_s     = 1'b0;
          end
          if (count_next_s != {CW{1'b0}}) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
    queue_full_next_s = (count_next_s == CW'(Q_DEPTH));
    drop_next_s       = (drop_cnt_s != 2'd0);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r      <= ST_IDLE;
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      sweep_r      <= {IW{1'b0}};
      wr_en_r      <= 1'b0;
      wr_index_r   <= {IW{1'b0}};
      wr_tag_r     <= 64'd0;
      wr_target_r  <= 64'd0;
      wr_valid_r   <= 1'b0;
      flush_busy_r <= 1'b0;
      queue_full_r <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      count_r      <= count_next_s;
      sweep_r      <= sweep_next_s;
      wr_en_r      <= wr_en_next_s;
      wr_index_r   <= wr_index_next_s;
      wr_tag_r     <= wr_tag_next_s;
      wr_target_r  <= wr_target_next_s;
      wr_valid_r   <= wr_valid_next_s;
      flush_busy_r <= flush_busy_next_s;
      queue_full_r <= queue_full_next_s;
      drop_r       <= drop_next_s;
    end
  end

  // FIFO storage; br lands before jmp, entries forwarded on an empty FIFO are stored and skipped.
  always_ff @(posedge clk) begin
    if (br_acc_s) begin
      mem_pc_r[wr_ptr_r]  <= bus.br_pc;
      mem_tgt_r[wr_ptr_r] <= bus.br_target;
    end
    if (jmp_acc_s) begin
      mem_pc_r[wr_ptr_r + PW'(br_acc_s)]  <= bus.jmp_pc;
      mem_tgt_r[wr_ptr_r + PW'(br_acc_s)] <= bus.jmp_target;
    end
  end

  assign bus.btb_wr_en     = wr_en_r;
  assign bus.btb_wr_index  = wr_index_r;
  assign bus.btb_wr_tag    = wr_tag_r;
  assign bus.btb_wr_target = wr_target_r;
  assign bus.btb_wr_valid  = wr_valid_r;
  assign bus.flush_busy    = flush_busy_r;
  assign bus.queue_full    = queue_full_r;
  assign bus.drop          = drop_r;

`ifdef BTB_UPD_STATS_EN
  logic [31:0] stat_writes_r, stat_drops_r;
  logic [32:0] drop_sum_s;

  // Saturating sum for the drop counter.
  always_comb begin
    drop_sum_s = {1'b0, stat_drops_r} + 33'(drop_cnt_s);
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_writes_r <= 32'd0;
      stat_drops_r  <= 32'd0;
    end else begin
      if (pop_s && (stat_writes_r != 32'hFFFF_FFFF)) begin
        stat_writes_r <= stat_writes_r + 32'd1;
      end
      stat_drops_r <= drop_sum_s[32] ? 32'hFFFF_FFFF : drop_sum_s[31:0];
    end
  end

  assign stat_writes = stat_writes_r;
  assign stat_drops  = stat_drops_r;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl (LOWER=5, Q_DEPTH=4).
module tb_btb_update_ctrl;
  localparam int LOWER   = 5;
  localparam int Q_DEPTH = 4;

  logic clk = 1'b0;
  logic arst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  btb_update_ctrl_if #(.LOWER(LOWER)) bus ();

`ifdef BTB_UPD_STATS_EN
  logic [31:0] stat_writes, stat_drops;
`endif

  btb_update_ctrl #(.LOWER(LOWER), .Q_DEPTH(Q_DEPTH)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .bus         (bus.slave)
`ifdef BTB_UPD_STATS_EN
    ,
    .stat_writes (stat_writes),
    .stat_drops  (stat_drops)
`endif
  );

  function automatic logic [63:0] pc_of(input int k);
    return 64'hA000_0000_0000_0000 | (64'(k) << 2);
  endfunction

  function automatic logic [63:0] tgt_of(input int k);
    return 64'h0000_0000_0000_1000 + 64'(k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.br_valid  = 1'b0;
    bus.jmp_valid = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic push(input int bk, input int jk);
    bus.br_valid   = (bk >= 0);
    bus.br_pc      = pc_of(bk);
    bus.br_target  = tgt_of(bk);
    bus.jmp_valid  = (jk >= 0);
    bus.jmp_pc     = pc_of(jk);
    bus.jmp_target = tgt_of(jk);
  endtask

  task automatic exp_wr(input string tag, input logic en, input logic [63:0] idx,
                        input logic [63:0] tg, input logic [63:0] tgt, input logic vld);
    check({tag, ".wr_en"}, 64'(bus.btb_wr_en), 64'(en));
    if (en) begin
      check({tag, ".index"}, 64'(bus.btb_wr_index), idx);
      check({tag, ".tag"}, bus.btb_wr_tag, tg);
      check({tag, ".target"}, bus.btb_wr_target, tgt);
      check({tag, ".valid"}, 64'(bus.btb_wr_valid), 64'(vld));
    end
  endtask

  task automatic exp_k(input string tag, input int k);
    exp_wr(tag, 1'b1, 64'(k % 8), pc_of(k), tgt_of(k), 1'b1);
  endtask

  task automatic exp_st(input string tag, input logic busy, input logic full, input logic drp);
    check({tag, ".flush_busy"}, 64'(bus.flush_busy), 64'(busy));
    check({tag, ".queue_full"}, 64'(bus.queue_full), 64'(full));
    check({tag, ".drop"}, 64'(bus.drop), 64'(drp));
  endtask

  task automatic exp_inv(input string tag, input int idx);
    exp_wr(tag, 1'b1, 64'(idx), 64'd0, 64'd0, 1'b0);
    check({tag, ".flush_busy"}, 64'(bus.flush_busy), 64'd1);
  endtask

  task automatic exp_all_zero(input string tag);
    exp_wr(tag, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0);
    check({tag, ".index"}, 64'(bus.btb_wr_index), 64'd0);
    check({tag, ".tag"}, bus.btb_wr_tag, 64'd0);
    check({tag, ".target"}, bus.btb_wr_target, 64'd0);
    check({tag, ".valid"}, 64'(bus.btb_wr_valid), 64'd0);
    exp_st(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    arst_n = 1'b0;
    bus.en = 1'b0;
    clear_req();
    push(-1, -1);
    clear_req();
    repeat (2) tick();
    exp_all_zero("reset");
    arst_n = 1'b1;
    tick();

    // Single branch on an empty FIFO: written at the very next edge.
    bus.en = 1'b1;
    bus.br_valid = 1'b1; bus.br_pc = 64'h1C; bus.br_target = 64'h400;
    tick();
    clear_req();
    exp_wr("t2", 1'b1, 64'd7, 64'h1C, 64'h400, 1'b1);
    exp_st("t2", 1'b0, 1'b0, 1'b0);
    tick();
    check("t2.idle_en", 64'(bus.btb_wr_en), 64'd0);
    check("t2.hold_tag", bus.btb_wr_tag, 64'h1C);

    // Branch + jump in one cycle: index 1 then index 2.
    bus.br_valid  = 1'b1; bus.br_pc  = 64'h4; bus.br_target  = 64'h100;
    bus.jmp_valid = 1'b1; bus.jmp_pc = 64'h8; bus.jmp_target = 64'h200;
    tick();
    clear_req();
    exp_wr("t3a", 1'b1, 64'd1, 64'h4, 64'h100, 1'b1);
    tick();
    exp_wr("t3b", 1'b1, 64'd2, 64'h8, 64'h200, 1'b1);
    tick();
    check("t3.done", 64'(bus.btb_wr_en), 64'd0);

    // Fill to Q_DEPTH with double pushes, then one-slot and no-slot cases.
    push(0, 1); tick(); exp_k("t4a", 0); exp_st("t4a", 1'b0, 1'b0, 1'b0);
    push(2, 3); tick(); exp_k("t4b", 1); exp_st("t4b", 1'b0, 1'b0, 1'b0);
    push(4, 5); tick(); exp_k("t4c", 2); exp_st("t4c", 1'b0, 1'b0, 1'b0);
    push(6, 7); tick(); exp_k("t4d", 3); exp_st("t4d", 1'b0, 1'b1, 1'b0);
    push(8, 9); tick(); exp_k("t4e", 4); exp_st("t4e", 1'b0, 1'b1, 1'b1);
    bus.en = 1'b0;
    push(10, 11); tick(); clear_req();
    check("t4f.wr_en", 64'(bus.btb_wr_en), 64'd0); exp_st("t4f", 1'b0, 1'b1, 1'b1);
    tick();
    check("t4g.wr_en", 64'(bus.btb_wr_en), 64'd0); exp_st("t4g", 1'b0, 1'b1, 1'b0);
    bus.en = 1'b1;
    tick(); exp_k("t4h", 5); exp_st("t4h", 1'b0, 1'b0, 1'b0);
    tick(); exp_k("t4i", 6);
    tick(); exp_k("t4j", 7);
    tick(); exp_k("t4k", 8);
    tick(); check("t4.empty", 64'(bus.btb_wr_en), 64'd0);

    // Flush with two entries queued; requests during the sweep are dropped.
    push(20, 21); tick(); clear_req(); exp_k("t5a", 20);
    push(22, 23); tick(); clear_req(); exp_k("t5b", 21);
    push(24, -1); bus.flush_req = 1'b1;
    tick(); clear_req();
    exp_inv("t5.row0", 0); exp_st("t5.row0", 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) push(25, -1);
      tick(); clear_req();
      exp_inv($sformatf("t5.row%0d", i), i);
      check($sformatf("t5.drop%0d", i), 64'(bus.drop), 64'(i == 3));
    end
    tick(); exp_wr("t5.end", 1'b0, 64'd0, 64'd0, 64'd0, 1'b0); exp_st("t5.end", 1'b0, 1'b0, 1'b0);
    tick(); check("t5.no_stale", 64'(bus.btb_wr_en), 64'd0);

    // Flush restarted at sweep index 5.
    bus.flush_req = 1'b1; tick(); clear_req(); exp_inv("t6.a0", 0);
    for (int i = 1; i <= 5; i++) begin
      tick(); exp_inv($sformatf("t6.a%0d", i), i);
    end
    bus.flush_req = 1'b1; tick(); clear_req(); exp_inv("t6.b0", 0);
    for (int i = 1; i < 8; i++) begin
      tick(); exp_inv($sformatf("t6.b%0d", i), i);
    end
    tick(); exp_wr("t6.end", 1'b0, 64'd0, 64'd0, 64'd0, 1'b0); exp_st("t6.end", 1'b0, 1'b0, 1'b0);

    // Reset while draining three queued entries.
    push(30, 31); tick(); exp_k("t1a", 30);
    push(32, 33); tick(); exp_k("t1b", 31);
    push(34, 35); tick(); clear_req(); exp_k("t1c", 32);
    arst_n = 1'b0;
    #1;
    exp_all_zero("t1.rst");
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t1.post%0d", i), 64'(bus.btb_wr_en), 64'd0);
    end
    exp_st("t1.post", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
